// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle controller:
// FSM states, ALUOp classes, ALUControl codes, opcodes and immediate formats.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the ALUOp class and instruction fields
// to the 3-bit ALUControl code driven into the alu block.
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    // Decode ALUOp/funct3; only R-type (op5=1) with funct7b5 selects subtract.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 && funct7b5) begin
                            alucontrol = ALU_SUB;
                        end else begin
                            alucontrol = ALU_ADD;
                        end
                    end
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle controller: Moore FSM sequencing the datapath one step per clock,
// plus ImmSrc decode, ALU decode and branch-qualified PC write enable.
module multicycle_control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr
);

    state_t     state_r;
    state_t     next_s;
    logic [1:0] aluop_s;
    logic       pcupdate_s;
    logic       branch_s;

    // State register with synchronous active-low reset back to FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; unsupported opcodes return to FETCH from DECODE.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH: next_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECUTER;
                    OP_I:         next_s = S_EXECUTEI;
                    OP_B:         next_s = S_BEQ;
                    OP_JAL:       next_s = S_JAL;
                    default:      next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op[5]) begin
                    next_s = S_MEMWRITE;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMREAD:  next_s = S_MEMWB;
            S_MEMWB:    next_s = S_FETCH;
            S_MEMWRITE: next_s = S_FETCH;
            S_EXECUTER: next_s = S_ALUWB;
            S_EXECUTEI: next_s = S_ALUWB;
            S_ALUWB:    next_s = S_FETCH;
            S_BEQ:      next_s = S_FETCH;
            S_JAL:      next_s = S_ALUWB;
            default:    next_s = S_FETCH;
        endcase
    end

    // Moore output decode per state; every output defaults to inactive.
    always_comb begin
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        RegWrite     = 1'b0;
        IllegalInstr = 1'b0;
        aluop_s      = ALUOP_ADD;
        pcupdate_s   = 1'b0;
        branch_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pcupdate_s = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL: IllegalInstr = 1'b0;
                    default:                                IllegalInstr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                aluop_s = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop_s = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                aluop_s  = ALUOP_SUB;
                branch_s = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pcupdate_s = 1'b1;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

    // funct3[0] distinguishes bne from beq, inverting the Zero sense.
    always_comb begin
        PCWrite = pcupdate_s | (branch_s & (Zero ^ funct3[0]));
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_LW, OP_I: ImmSrc = IMM_I;
            OP_SW:       ImmSrc = IMM_S;
            OP_B:        ImmSrc = IMM_B;
            OP_JAL:      ImmSrc = IMM_J;
            default:     ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop_s),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

endmodule
